// File: rtl/boid_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : boid_pair_sequencer
// Brief   : Frame-level all-pairs sequencer for the boid force/velocity
//           datapath: own-state read, neighbour stream, drain, field write-back.
// Revision: 1.0 - initial release
// ============================================================================
module boid_pair_sequencer #(
    parameter int N_BOIDS  = 2,
    parameter int DP_LAT   = 2,
    parameter int W_FIELDS = 7,
    localparam int IW      = $clog2(N_BOIDS) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [IW-1:0]       num_active,
    output logic [IW-1:0]       which_boid,
    output logic [IW-1:0]       other_boid,
    output logic                r_en_tot,
    output logic                r_en_itr,
    output logic                dp_en,
    output logic [W_FIELDS-1:0] w_en,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam int c_cnt_max = (DP_LAT > W_FIELDS) ? DP_LAT : W_FIELDS;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [IW-1:0]      c_n_max      = IW'(N_BOIDS);
    localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DP_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_write_last = c_cnt_w'(W_FIELDS - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_self = 3'd1;
    localparam logic [2:0] c_st_iter    = 3'd2;
    localparam logic [2:0] c_st_drain   = 3'd3;
    localparam logic [2:0] c_st_write   = 3'd4;

    // Sequencing state
    logic [2:0]          r_state;
    logic [IW-1:0]       r_n;
    logic [IW-1:0]       r_i;
    logic [IW-1:0]       r_j;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_fin;

    // Registered outputs
    logic [IW-1:0]       r_which_boid;
    logic [IW-1:0]       r_other_boid;
    logic                r_tot_strb;
    logic                r_itr_strb;
    logic                r_dp_en;
    logic [W_FIELDS-1:0] r_w_en;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;

    // Next-state values
    logic [2:0]          w_state_nx;
    logic [IW-1:0]       w_n_nx;
    logic [IW-1:0]       w_i_nx;
    logic [IW-1:0]       w_j_nx;
    logic [c_cnt_w-1:0]  w_cnt_nx;
    logic                w_fin_nx;
    logic                w_overrun_nx;

    // Next output values
    logic [IW-1:0]       w_which_d;
    logic [IW-1:0]       w_other_d;
    logic                w_tot_d;
    logic                w_itr_d;
    logic                w_dp_d;
    logic [W_FIELDS-1:0] w_we_d;
    logic                w_busy_d;
    logic                w_done_d;

    logic                w_accept;
    logic [IW-1:0]       w_n_clamp;
    logic [IW-1:0]       w_j_p1;
    logic [IW-1:0]       w_j_p2;
    logic [IW-1:0]       w_j_inc;
    logic [IW-1:0]       w_i_p1;

    // Outputs trail the state by one cycle, so a start is refused until the
    // registered busy flag has also dropped (the done cycle accepts again).
    assign w_accept  = en && (r_state == c_st_idle) && !r_busy;
    assign w_n_clamp = (num_active > c_n_max) ? c_n_max : num_active;
    assign w_j_p1    = r_j + IW'(1);
    assign w_j_p2    = r_j + IW'(2);
    assign w_j_inc   = (w_j_p1 == r_i) ? w_j_p2 : w_j_p1;
    assign w_i_p1    = r_i + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_n          <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_cnt        <= '0;
            r_fin        <= 1'b0;
            r_which_boid <= '0;
            r_other_boid <= '0;
            r_tot_strb   <= 1'b0;
            r_itr_strb   <= 1'b0;
            r_dp_en      <= 1'b0;
            r_w_en       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_n          <= w_n_nx;
            r_i          <= w_i_nx;
            r_j          <= w_j_nx;
            r_cnt        <= w_cnt_nx;
            r_fin        <= w_fin_nx;
            r_which_boid <= w_which_d;
            r_other_boid <= w_other_d;
            r_tot_strb   <= w_tot_d;
            r_itr_strb   <= w_itr_d;
            r_dp_en      <= w_dp_d;
            r_w_en       <= w_we_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
            r_overrun    <= w_overrun_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_n_nx       = r_n;
        w_i_nx       = r_i;
        w_j_nx       = r_j;
        w_cnt_nx     = r_cnt;
        w_fin_nx     = 1'b0;
        w_overrun_nx = r_overrun;

        if (w_accept) begin
            w_overrun_nx = 1'b0;
        end else if (en) begin
            w_overrun_nx = 1'b1;
        end

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_n_nx   = w_n_clamp;
                    w_i_nx   = '0;
                    w_cnt_nx = '0;
                    if (w_n_clamp == '0) begin
                        w_fin_nx = 1'b1;
                    end else begin
                        w_state_nx = c_st_rd_self;
                    end
                end
            end
            c_st_rd_self: begin
                w_cnt_nx = '0;
                if (r_n > IW'(1)) begin
                    w_state_nx = c_st_iter;
                    w_j_nx     = (r_i == '0) ? IW'(1) : '0;
                end else begin
                    w_state_nx = c_st_drain;
                end
            end
            c_st_iter: begin
                if (w_j_inc >= r_n) begin
                    w_state_nx = c_st_drain;
                    w_cnt_nx   = '0;
                end else begin
                    w_j_nx = w_j_inc;
                end
            end
            c_st_drain: begin
                if (r_cnt == c_drain_last) begin
                    w_state_nx = c_st_write;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_w'(1);
                end
            end
            c_st_write: begin
                if (r_cnt == c_write_last) begin
                    w_cnt_nx = '0;
                    if (w_i_p1 < r_n) begin
                        w_i_nx     = w_i_p1;
                        w_state_nx = c_st_rd_self;
                    end else begin
                        w_state_nx = c_st_idle;
                        w_fin_nx   = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nx = c_st_idle;
            end
        endcase
    end

    // Output decode of the current state; registered on the next edge
    always_comb begin
        w_which_d = r_which_boid;
        w_other_d = r_other_boid;
        w_tot_d   = 1'b0;
        w_itr_d   = 1'b0;
        w_dp_d    = r_itr_strb;
        w_we_d    = '0;
        w_busy_d  = (r_state != c_st_idle);
        w_done_d  = r_fin;

        case (r_state)
            c_st_idle: begin
                w_which_d = '0;
                w_other_d = '0;
            end
            c_st_rd_self: begin
                w_which_d = r_i;
                w_tot_d   = 1'b1;
            end
            c_st_iter: begin
                w_which_d = r_i;
                w_other_d = r_j;
                w_itr_d   = 1'b1;
            end
            c_st_drain: begin
                w_which_d = r_i;
            end
            c_st_write: begin
                w_which_d = r_i;
                w_we_d    = W_FIELDS'(1) << r_cnt;
            end
            default: begin
                w_which_d = '0;
            end
        endcase
    end

    assign which_boid = r_which_boid;
    assign other_boid = r_other_boid;
    assign r_en_tot   = r_tot_strb;
    assign r_en_itr   = r_itr_strb;
    assign dp_en      = r_dp_en;
    assign w_en       = r_w_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_boid_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_boid_pair_sequencer
// Brief   : Cycle-accurate scoreboard bench for boid_pair_sequencer across
//           four parameterisations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_boid_pair_sequencer;

    typedef struct packed {
        logic       busy;
        logic       tot;
        logic       itr;
        logic       dp;
        logic       done;
        logic [6:0] we;
        logic [2:0] wb;
        logic [2:0] ob;
    } rec_t;

    logic       clk;
    logic       reset;
    logic [3:0] en_a;
    logic [2:0] na;
    logic [1:0] sel;
    int         tests_run;
    int         tests_failed;
    rec_t       q[$];

    wire  [1:0]      wb0;
    wire  [1:0]      ob0;
    wire  [3:1][2:0] wb;
    wire  [3:1][2:0] ob;
    wire  [3:0]      tot;
    wire  [3:0]      itr;
    wire  [3:0]      dp;
    wire  [3:0]      bsy;
    wire  [3:0]      dn;
    wire  [3:0]      ov;
    wire  [3:0][6:0] we;

    rec_t v;
    logic v_ovr;

    boid_pair_sequencer #(.N_BOIDS(2), .DP_LAT(2), .W_FIELDS(7)) u_dut0 (
        .clk(clk), .reset(reset), .en(en_a[0]), .num_active(na[1:0]),
        .which_boid(wb0), .other_boid(ob0), .r_en_tot(tot[0]), .r_en_itr(itr[0]),
        .dp_en(dp[0]), .w_en(we[0]), .busy(bsy[0]), .done(dn[0]), .overrun(ov[0]));

    // dut1: clamp case, dut2/dut3: drain-latency sweep
    for (genvar g = 1; g < 4; g++) begin : g_dut
        boid_pair_sequencer #(
            .N_BOIDS(4), .DP_LAT((g == 1) ? 2 : (g == 2) ? 1 : 5), .W_FIELDS(7)
        ) u_dut (
            .clk(clk), .reset(reset), .en(en_a[g]), .num_active(na),
            .which_boid(wb[g]), .other_boid(ob[g]), .r_en_tot(tot[g]), .r_en_itr(itr[g]),
            .dp_en(dp[g]), .w_en(we[g]), .busy(bsy[g]), .done(dn[g]), .overrun(ov[g]));
    end

    always #5 clk = ~clk;

    always_comb begin
        v       = '0;
        v.busy  = bsy[sel];
        v.tot   = tot[sel];
        v.itr   = itr[sel];
        v.dp    = dp[sel];
        v.done  = dn[sel];
        v.we    = we[sel];
        v_ovr   = ov[sel];
        if (sel == 2'd0) begin
            v.wb = {1'b0, wb0};
            v.ob = {1'b0, ob0};
        end else begin
            v.wb = wb[sel];
            v.ob = ob[sel];
        end
    end

    // Expected output trace, one record per cycle starting right after the accept edge
    task automatic build_model(input int n, input int dplat, input int wf);
        rec_t       r;
        logic       prev_itr;
        logic [2:0] last_ob;
        prev_itr = 1'b0;
        last_ob  = 3'd0;
        r = '0;
        q.push_back(r);
        for (int i = 0; i < n; i++) begin
            r = '0; r.busy = 1'b1; r.tot = 1'b1; r.wb = 3'(i); r.ob = last_ob; r.dp = prev_itr;
            q.push_back(r);
            prev_itr = 1'b0;
            for (int j = 0; j < n; j++) begin
                if (j != i) begin
                    r = '0; r.busy = 1'b1; r.itr = 1'b1; r.wb = 3'(i); r.ob = 3'(j); r.dp = prev_itr;
                    q.push_back(r);
                    prev_itr = 1'b1;
                    last_ob  = 3'(j);
                end
            end
            for (int k = 0; k < dplat; k++) begin
                r = '0; r.busy = 1'b1; r.wb = 3'(i); r.ob = last_ob; r.dp = prev_itr;
                q.push_back(r);
                prev_itr = 1'b0;
            end
            for (int k = 0; k < wf; k++) begin
                r = '0; r.busy = 1'b1; r.we = 7'(1 << k); r.wb = 3'(i); r.ob = last_ob;
                q.push_back(r);
            end
        end
        r = '0; r.done = 1'b1; r.dp = prev_itr;
        q.push_back(r);
    endtask

    task automatic run_pass(input logic [1:0] s, input int num, input int n, input int dplat,
                            input int inj, input bit chain_in, input bit chain_out,
                            input int abort_at);
        rec_t e;
        rec_t o;
        int   c;
        int   nb, ndp, ntot, nquiet;
        int   nwe[7];
        bit   we_ok;
        sel = s;
        q.delete();
        build_model(n, dplat, 7);
        nb = 0; ndp = 0; ntot = 0; nquiet = 0;
        for (int b = 0; b < 7; b++) nwe[b] = 0;
        if (!chain_in) begin
            @(negedge clk);
            na      = 3'(num);
            en_a[s] = 1'b1;
        end
        c = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            en_a[s] = (c == inj) || (chain_out && q.size() == 1);
            e = q.pop_front();
            o = v;
            tests_run++;
            if (({o.busy, o.tot, o.itr, o.dp, o.done, o.we, o.ob} !==
                 {e.busy, e.tot, e.itr, e.dp, e.done, e.we, e.ob}) ||
                (e.busy && (o.wb !== e.wb))) begin
                tests_failed++;
                $display("FAIL trace dut%0d cycle %0d: got %h expected %h (busy,tot,itr,dp,done,we,wb,ob)",
                         s, c, o, e);
            end
            if (o.busy) nb++;
            if (o.dp) ndp++;
            if (o.tot) ntot++;
            if (o.busy && !o.tot && !o.itr && (o.we == 7'd0)) nquiet++;
            for (int b = 0; b < 7; b++) nwe[b] += int'(o.we[b]);
            if (c == abort_at) begin
                reset = 1'b1;
                q.delete();
            end
            c++;
        end
        if (abort_at < 0) begin
            tests_run++;
            if (nb !== n * (n + dplat + 7)) begin
                tests_failed++;
                $display("FAIL busy_count dut%0d: got %0d expected %0d", s, nb, n * (n + dplat + 7));
            end
            tests_run++;
            if (ndp !== n * (n - 1)) begin
                tests_failed++;
                $display("FAIL dp_count dut%0d: got %0d expected %0d", s, ndp, n * (n - 1));
            end
            tests_run++;
            if (ntot !== n) begin
                tests_failed++;
                $display("FAIL tot_count dut%0d: got %0d expected %0d", s, ntot, n);
            end
            tests_run++;
            if (nquiet !== n * dplat) begin
                tests_failed++;
                $display("FAIL drain_cycles dut%0d: got %0d expected %0d", s, nquiet, n * dplat);
            end
            we_ok = 1'b1;
            for (int b = 0; b < 7; b++) if (nwe[b] !== n) we_ok = 1'b0;
            tests_run++;
            if (!we_ok) begin
                tests_failed++;
                $display("FAIL we_counts dut%0d: got %0d %0d %0d %0d %0d %0d %0d expected %0d each",
                         s, nwe[0], nwe[1], nwe[2], nwe[3], nwe[4], nwe[5], nwe[6], n);
            end
            tests_run++;
            if (v_ovr !== (inj >= 0)) begin
                tests_failed++;
                $display("FAIL overrun dut%0d: got %0b expected %0b", s, v_ovr, (inj >= 0));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            tests_run++;
            if ({v, v_ovr} !== '0) begin
                tests_failed++;
                $display("FAIL reset_state dut%0d: got %h expected 0", s, {v, v_ovr});
            end
        end
    endtask

    task automatic test_default();
        run_pass(2'd0, 2, 2, 2, -1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_single();
        run_pass(2'd0, 1, 1, 2, -1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_zero_and_clamp();
        run_pass(2'd0, 0, 0, 2, -1, 1'b0, 1'b0, -1);
        run_pass(2'd1, 7, 4, 2, -1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_overrun_back_to_back();
        run_pass(2'd0, 2, 2, 2, 2, 1'b0, 1'b1, -1);
        run_pass(2'd0, 2, 2, 2, -1, 1'b1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_write();
        run_pass(2'd0, 2, 2, 2, -1, 1'b0, 1'b0, 18);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            reset = 1'b0;
            tests_run++;
            if ({v, v_ovr} !== '0) begin
                tests_failed++;
                $display("FAIL post_reset_quiet cycle %0d: got %h expected 0", c, {v, v_ovr});
            end
        end
        run_pass(2'd0, 2, 2, 2, -1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_dp_lat_sweep();
        run_pass(2'd2, 3, 3, 1, -1, 1'b0, 1'b0, -1);
        run_pass(2'd3, 3, 3, 5, -1, 1'b0, 1'b0, -1);
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        en_a         = '0;
        na           = '0;
        sel          = 2'd0;
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_default();
        test_single();
        test_zero_and_clamp();
        test_overrun_back_to_back();
        test_reset_mid_write();
        test_dp_lat_sweep();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
